systolic_stream_feeder: RTL
===========================

Name: systolic_stream_feeder

Overview:
- Host-side transmitter/collector for the FP4×INT8 `systolic_array`.
- Accepts a job command and a stream of k-step operand words over valid/ready, and serializes each word into the array's per-cycle byte inputs in slice lockstep.
- Issues the combined readout pulse, captures the serialized 8-bit result bytes the array emits, and re-emits them to the host over a valid/ready byte stream.

Parameters:
- SLICES, 2, array slice count; W=SLICES columns, H=2*SLICES rows.
- KW, 16, width of k-step count.
- DRAIN_CYCLES, 2*SLICES, zero-data cycles between last issued byte and readout pulse.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start_valid  in  1  job command valid
- start_ready  out  1  high in IDLE only
- start_k  in  KW  k-steps in job (0 legal)
- op_valid  in  1  operand word valid
- op_ready  out  1  operand word ready
- op_left  in  H*4  fp4 per row, row r at [r*4+:4]
- op_top  in  W*8  int8 per column, column c at [c*8+:8]
- arr_in_left  out  8  to array in_left
- arr_in_top  out  8  to array in_top
- arr_readout  out  1  drives array restart_inputs, reset_accumulators, copy_accumulator_values_to_out_queue, restart_out_queue
- arr_out  in  8  array out byte
- res_valid  out  1  result byte valid
- res_ready  in  1  result byte ready
- res_data  out  8  result byte
- res_last  out  1  high on final byte (index W*H-1)
- busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high; clock clk. State IDLE, phase=0, counters=0, hold empty, shift regs=0. arr_in_* =0, arr_readout=0, res_valid=0, res_last=0, res_data=0, op_ready=0, busy=0, start_ready=1. Feeder reset must coincide with array reset.
- phase: mirrors array slice_counter.
  - Cleared on reset or arr_readout.
  - Else increments, wrapping SLICES-1→0.
  - SLICES=1: phase is always 0.
- Shift regs L (H*4 bits), T (W*8 bits):
  - arr_in_left=L[7:0] and arr_in_top=T[7:0] every cycle; each shifts right by 8 per cycle, zero-fill.
  - Byte s of a word goes out at phase s.
  - Outside FEED step issue they hold zeros.
- Hold register: one entry; op_ready = (state==FEED) && !hold_full && (accepted<k). Handshake on op_valid&&op_ready; accepted increments.
- States:
  - IDLE: on start_valid, latch k=start_k, clear accepted/issued, go FEED.
  - FEED, at each phase==0 cycle:
    - if issued==k: go DRAIN.
    - elif hold_full: load L/T from hold, hold empty, issued++.
    - else: bubble. L/T stay zero, so fp4 exp 0 contributes nothing; issued unchanged.
    - Hold may load the same cycle it empties.
  - DRAIN: DRAIN_CYCLES cycles, zero data, then READOUT.
  - READOUT: arr_readout=1 for exactly one cycle, then CAPTURE.
  - CAPTURE: the W*H cycles following the pulse, arr_out is written to buf[0..W*H-1] in order. Must not stall; no backpressure toward the array. Then EMIT.
  - EMIT: res_valid=1, res_data=buf[idx], res_last=(idx==W*H-1). idx advances on res_valid&&res_ready; after last transfer go IDLE. res_data/res_last stable while res_valid&&!res_ready.
- Result byte n = row n/W, column n%W. Value is accumulator>>10, truncated to 8 bits, arithmetic shift.
- start_k=0: FEED exits at the first phase==0 cycle; the job returns W*H bytes of 0x00.
- op_valid outside FEED, or beyond k words: ignored, not accepted.
- Reset mid-job: immediate return to reset values; any partial result is discarded.

Optional Feature:
- Macro FEEDER_UNDERRUN_CNT_EN.
- Defined:
  - Adds output port underruns (16 bits).
  - Counts bubble k-steps, saturating at 0xFFFF.
  - Cleared on reset and on IDLE→FEED.
- Undefined: port absent, no counter logic.

Test Plan (SLICES=2, W=2, H=4, 8 result bytes):
- Basic: start_k=16; every word left rows {0x7,0xF,0x7,0xF}, top {127,64}, op_valid held 1 → bytes 0x7F,0x40,0x81,0xC0,0x7F,0x40,0x81,0xC0; res_last only on byte 7.
- Bubbles: same job, op_valid low across 3 step boundaries → identical bytes; underruns=3 when FEEDER_UNDERRUN_CNT_EN is defined.
- Zero job: start_k=0 → arr_readout pulses once, 8 bytes 0x00, busy falls after byte 7 transfers.
- Backpressure: res_ready toggled 1-0-0-1 during EMIT → res_data stable while stalled; start_ready=0 until last byte; start_valid during EMIT ignored.
- Reset mid-FEED, after 5 of 16 steps → next cycle all outputs at reset values. Rerunning the Basic job then yields the Basic bytes.
- Back-to-back: Basic job then job with all rows 0x0 → second job returns 8×0x00, confirming accumulators were cleared by the readout.

Source files
------------

// File: rtl/systolic_stream_feeder.sv
// Host-side feeder/collector for the FP4xINT8 systolic array: serializes operand words per slice
// phase, pulses readout, captures result bytes and re-emits them. FEEDER_UNDERRUN_CNT_EN adds underruns.
module systolic_stream_feeder #(
  parameter int SLICES       = 2,
  parameter int KW           = 16,
  parameter int DRAIN_CYCLES = 2 * SLICES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [KW-1:0]       start_k,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [8*SLICES-1:0] op_left,
  input  logic [8*SLICES-1:0] op_top,
  output logic [7:0]          arr_in_left,
  output logic [7:0]          arr_in_top,
  output logic                arr_readout,
  input  logic [7:0]          arr_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [7:0]          res_data,
  output logic                res_last,
  output logic                busy
`ifdef FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underruns
`endif
);

  // state   | meaning
  // IDLE    | waiting for a job command
  // FEED    | issuing one k-step (or bubble) per SLICES cycles
  // DRAIN   | zero data while the array pipeline empties
  // READOUT | single-cycle readout pulse
  // CAPTURE | writing the array's result bytes into the buffer
  // EMIT    | streaming buffered bytes to the host
  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_DRAIN, S_READOUT, S_CAPTURE, S_EMIT
  } state_t;

  localparam int NB = 2 * SLICES * SLICES;
  localparam int PW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int IW = $clog2(NB);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t              state;
  logic [PW-1:0]       phase;
  logic [KW-1:0]       k_reg;
  logic [KW-1:0]       accepted;
  logic [KW-1:0]       issued;
  logic                hold_full;
  logic [8*SLICES-1:0] hold_l;
  logic [8*SLICES-1:0] hold_t;
  logic [8*SLICES-1:0] sh_l;
  logic [8*SLICES-1:0] sh_t;
  logic [DW-1:0]       drain_cnt;
  logic [IW-1:0]       cap_idx;
  logic [IW-1:0]       res_idx;
  logic [7:0]          res_buf [NB];
  logic                step_edge;
  logic                accept;

  // Step decisions are taken on the last phase so byte s of a loaded word leaves at phase s.
  assign step_edge   = (phase == PW'(SLICES - 1));
  assign op_ready    = (state == S_FEED) && !hold_full && (accepted < k_reg);
  assign accept      = op_valid && op_ready;
  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign arr_readout = (state == S_READOUT);
  assign arr_in_left = sh_l[7:0];
  assign arr_in_top  = sh_t[7:0];
  assign res_valid   = (state == S_EMIT);
  assign res_data    = res_valid ? res_buf[res_idx] : 8'h00;
  assign res_last    = res_valid && (res_idx == IW'(NB - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= '0;
      k_reg     <= '0;
      accepted  <= '0;
      issued    <= '0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_t    <= '0;
      sh_l      <= '0;
      sh_t      <= '0;
      drain_cnt <= '0;
      cap_idx   <= '0;
      res_idx   <= '0;
      for (int i = 0; i < NB; i++) res_buf[i] <= '0;
    end else begin
      phase <= (arr_readout || step_edge) ? '0 : phase + PW'(1);
      sh_l  <= sh_l >> 8;
      sh_t  <= sh_t >> 8;
      if (accept) begin
        hold_l    <= op_left;
        hold_t    <= op_top;
        hold_full <= 1'b1;
        accepted  <= accepted + KW'(1);
      end
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            k_reg    <= start_k;
            accepted <= '0;
            issued   <= '0;
            state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (step_edge) begin
            if (issued == k_reg) begin
              drain_cnt <= DW'(DRAIN_CYCLES - 1);
              state     <= S_DRAIN;
            end else if (hold_full) begin
              sh_l      <= hold_l;
              sh_t      <= hold_t;
              hold_full <= 1'b0;
              issued    <= issued + KW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_READOUT;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        S_READOUT: begin
          cap_idx <= '0;
          state   <= S_CAPTURE;
        end
        S_CAPTURE: begin
          res_buf[cap_idx] <= arr_out;
          if (cap_idx == IW'(NB - 1)) begin
            res_idx <= '0;
            state   <= S_EMIT;
          end else begin
            cap_idx <= cap_idx + IW'(1);
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            if (res_idx == IW'(NB - 1)) state <= S_IDLE;
            else res_idx <= res_idx + IW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FEEDER_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underruns <= '0;
    end else if (state == S_IDLE && start_valid) begin
      underruns <= '0;
    end else if (state == S_FEED && step_edge && issued != k_reg && !hold_full &&
                 underruns != 16'hFFFF) begin
      underruns <= underruns + 16'd1;
    end
  end
`endif

endmodule
